// File: rtl/phy_txrx_pkg.sv
// Shared encodings for the USB-PD PHY TX/RX arbiter: TX FSM states and result codes.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package phy_txrx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_CHECK_CC     = 3'd1,
        ST_WAIT_CC_IDLE = 3'd2,
        ST_IFG_WAIT     = 3'd3,
        ST_TRANSFER     = 3'd4
    } tx_state_t;

    localparam logic [1:0] TX_RES_SENT    = 2'd0;
    localparam logic [1:0] TX_RES_CC_BUSY = 2'd1;
    localparam logic [1:0] TX_RES_ABORTED = 2'd2;

    localparam logic [1:0] RX_RES_OK       = 2'd0;
    localparam logic [1:0] RX_RES_CRC_ERR  = 2'd1;
    localparam logic [1:0] RX_RES_PAYLOAD  = 2'd2;
    localparam logic [1:0] RX_RES_TIMEOUT  = 2'd3;

endpackage

// File: rtl/phy_rx_byte_fifo.sv
// Show-ahead byte FIFO for assembled RX bytes (DEPTH entries, power of two, >= 2).
// Latency: a pushed byte is visible on pop_dat/vld the cycle after the push.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module phy_rx_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_dat,
    input  logic       pop,
    output logic [7:0] pop_dat,
    output logic       vld,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_pop;
    logic        do_push;

    assign vld     = (wr_ptr != rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && vld;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/phy_txrx_arbiter.sv
// USB-PD PHY TX/RX control: CC-arbitrated TX with retries, inter-frame gap, RX nibble-to-byte assembly.
// Latency: TX/RX done pulses one cycle after their event; bytes at N+1 (pulse) or N+2 (with FIFO).
// Backpressure: none without PHY_TXRX_RX_FIFO_EN; with it, bytes queue until pl_rx_byte_rdy, overflow drops and flags.
module phy_txrx_arbiter
    import phy_txrx_pkg::*;
#(
    parameter int IFG_CYCLES    = 1300,
    parameter int IFG_W         = 11,
    parameter int CC_RETRY_MAX  = 3,
    parameter int TYPE_W        = 3,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pl_rx_select,
    output logic              txrx_select,
    output logic              txrx_clr,
    input  logic              pl_tx_req,
    input  logic [TYPE_W-1:0] pl_tx_type,
    output logic              pl_tx_done,
    output logic [1:0]        pl_tx_result,
    output logic              phy_tx_en,
    output logic [TYPE_W-1:0] phy_tx_type,
    input  logic              phy_tx_done,
    output logic              idle_chk_en,
    input  logic              idle_chk_done,
    input  logic              idle_chk_result,
    input  logic              phy_rx_en,
    input  logic [TYPE_W-1:0] phy_rx_type,
    input  logic              phy_rx_nib_vld,
    input  logic [3:0]        phy_rx_nib,
    input  logic              phy_rx_eop,
    input  logic              phy_rx_crc_err,
    input  logic              phy_rx_payload_err,
    input  logic              phy_rx_timeout,
    output logic              pl_rx_en,
    output logic [TYPE_W-1:0] pl_rx_type,
    output logic              pl_rx_done,
    output logic [1:0]        pl_rx_result,
    output logic              pl_rx_byte_vld,
    output logic [7:0]        pl_rx_byte,
    input  logic              pl_rx_byte_rdy,
    output logic              pl_rx_ovf
);
    localparam int                CNT_W     = $clog2(CC_RETRY_MAX + 2);
    localparam logic [CNT_W-1:0]  RETRY_MAX = CNT_W'(CC_RETRY_MAX);
    localparam logic [IFG_W-1:0]  IFG_LAST  = IFG_W'(IFG_CYCLES - 1);

    tx_state_t        state, state_nxt;
    logic [CNT_W-1:0] retry_cnt, retry_nxt;
    logic             tx_done_nxt;
    logic [1:0]       tx_result_nxt;
    logic             ifg_active;
    logic [IFG_W-1:0] ifg_cnt;
    logic             ifg_load;
    logic             rx_done_evt;
    logic             rx_en_q;
    logic             rx_rise;
    logic             phase;
    logic [3:0]       nib_lo;
    logic             byte_wr;
    logic [7:0]       byte_dat;

    assign txrx_select = !pl_rx_select;
    assign phy_tx_type = pl_tx_type;
    assign phy_tx_en   = (state == ST_TRANSFER);
    assign idle_chk_en = (state == ST_CHECK_CC) || (state == ST_WAIT_CC_IDLE);
    assign pl_rx_en    = phy_rx_en;
    assign pl_rx_type  = phy_rx_type;
    assign rx_done_evt = phy_rx_eop || phy_rx_payload_err || phy_rx_timeout;
    assign rx_rise     = phy_rx_en && !rx_en_q;
    assign ifg_load    = (tx_done_nxt && (tx_result_nxt == TX_RES_SENT)) || rx_done_evt;

    // TX FSM state and retry counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            retry_cnt <= '0;
        end else begin
            state     <= state_nxt;
            retry_cnt <= retry_nxt;
        end
    end

    // TX next-state: RX select aborts everything except an in-flight transfer.
    always_comb begin
        state_nxt     = state;
        retry_nxt     = retry_cnt;
        tx_done_nxt   = 1'b0;
        tx_result_nxt = TX_RES_SENT;
        case (state)
            ST_IDLE: begin
                if (pl_tx_req) begin
                    state_nxt = ST_CHECK_CC;
                    retry_nxt = '0;
                end
            end
            ST_CHECK_CC: begin
                if (pl_rx_select) begin
                    state_nxt     = ST_IDLE;
                    tx_done_nxt   = 1'b1;
                    tx_result_nxt = TX_RES_ABORTED;
                end else if (idle_chk_done) begin
                    state_nxt = idle_chk_result ? ST_IFG_WAIT : ST_WAIT_CC_IDLE;
                end
            end
            ST_WAIT_CC_IDLE: begin
                if (pl_rx_select) begin
                    state_nxt     = ST_IDLE;
                    tx_done_nxt   = 1'b1;
                    tx_result_nxt = TX_RES_ABORTED;
                end else if (idle_chk_done && idle_chk_result) begin
                    if (retry_cnt < RETRY_MAX) begin
                        retry_nxt = retry_cnt + 1'b1;
                        state_nxt = ST_CHECK_CC;
                    end else begin
                        state_nxt     = ST_IDLE;
                        tx_done_nxt   = 1'b1;
                        tx_result_nxt = TX_RES_CC_BUSY;
                    end
                end
            end
            ST_IFG_WAIT: begin
                if (pl_rx_select) begin
                    state_nxt     = ST_IDLE;
                    tx_done_nxt   = 1'b1;
                    tx_result_nxt = TX_RES_ABORTED;
                end else if (!ifg_active) begin
                    state_nxt = ST_TRANSFER;
                end
            end
            ST_TRANSFER: begin
                if (phy_tx_done) begin
                    state_nxt   = ST_IDLE;
                    tx_done_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered TX completion; result holds until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pl_tx_done   <= 1'b0;
            pl_tx_result <= TX_RES_SENT;
        end else begin
            pl_tx_done <= tx_done_nxt;
            if (tx_done_nxt) pl_tx_result <= tx_result_nxt;
        end
    end

    // Inter-frame gap timer: active for IFG_CYCLES cycles after each load, reload restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifg_active <= 1'b0;
            ifg_cnt    <= '0;
        end else if (ifg_load) begin
            ifg_active <= 1'b1;
            ifg_cnt    <= '0;
        end else if (ifg_active) begin
            if (ifg_cnt == IFG_LAST) ifg_active <= 1'b0;
            else                     ifg_cnt    <= ifg_cnt + 1'b1;
        end
    end

    // RX completion with eop > payload_err > timeout priority; clear pulse trails done by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pl_rx_done   <= 1'b0;
            pl_rx_result <= RX_RES_OK;
            txrx_clr     <= 1'b0;
        end else begin
            pl_rx_done <= rx_done_evt;
            txrx_clr   <= pl_rx_done;
            if (phy_rx_eop)              pl_rx_result <= phy_rx_crc_err ? RX_RES_CRC_ERR : RX_RES_OK;
            else if (phy_rx_payload_err) pl_rx_result <= RX_RES_PAYLOAD;
            else if (phy_rx_timeout)     pl_rx_result <= RX_RES_TIMEOUT;
        end
    end

    // Nibble pairing, low nibble first; a rising phy_rx_en or EOP restarts the pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_en_q  <= 1'b0;
            phase    <= 1'b0;
            nib_lo   <= '0;
            byte_wr  <= 1'b0;
            byte_dat <= '0;
        end else begin
            rx_en_q <= phy_rx_en;
            byte_wr <= 1'b0;
            if (phy_rx_nib_vld) begin
                if (phase && !rx_rise) begin
                    byte_wr  <= 1'b1;
                    byte_dat <= {phy_rx_nib, nib_lo};
                    phase    <= 1'b0;
                end else begin
                    nib_lo <= phy_rx_nib;
                    phase  <= 1'b1;
                end
            end else if (rx_rise) begin
                phase <= 1'b0;
            end
            if (phy_rx_eop) phase <= 1'b0;
        end
    end

`ifdef PHY_TXRX_RX_FIFO_EN
    logic       fifo_full;
    logic       fifo_pop;
    logic [7:0] fifo_dat;
    logic       ovf_q;

    assign fifo_pop   = pl_rx_byte_vld && pl_rx_byte_rdy;
    assign pl_rx_byte = pl_rx_byte_vld ? fifo_dat : 8'h00;
    assign pl_rx_ovf  = ovf_q;

    phy_rx_byte_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (byte_wr),
        .push_dat (byte_dat),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .vld      (pl_rx_byte_vld),
        .full     (fifo_full)
    );

    // Sticky overflow: a byte lost to a full FIFO, cleared when a new packet starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                ovf_q <= 1'b0;
        else if (rx_rise)                          ovf_q <= 1'b0;
        else if (byte_wr && fifo_full && !fifo_pop) ovf_q <= 1'b1;
    end
`else
    logic unused_rdy;

    assign unused_rdy     = pl_rx_byte_rdy;
    assign pl_rx_byte_vld = byte_wr;
    assign pl_rx_byte     = byte_dat;
    assign pl_rx_ovf      = 1'b0;
`endif

endmodule
